// File: rtl/arq_ctrl_pkg.sv
// arq_ctrl_pkg: shared sender-side ARQ types and frame geometry.
// Holds the ARQ state encoding and the default frame/timeout/retry sizes.
package arq_ctrl_pkg;

  localparam int ARQ_FRAME_LEN   = 6016;
  localparam int ARQ_ACK_TIMEOUT = 4096;
  localparam int ARQ_MAX_RETRY   = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RETX = 3'd3,
    ST_DROP = 3'd4
  } arq_state_e;

endpackage

// File: rtl/arq_ctrl_if.sv
// arq_ctrl_if: line-side bundle between the mapper/return path and arq_ctrl.
// master drives i_* (mapper, verdict path); slave is arq_ctrl (drives o_*).
interface arq_ctrl_if #(
  parameter int RW = 2
);

  logic          i_arq_en;
  logic          i_frame_data_valid;
  logic          i_frame_data_fas;
  logic          i_ack_valid;
  logic          i_ack;
  logic          o_send_hold;
  logic          o_line_retrans_req;
  logic          o_frame_drop;
  logic [RW-1:0] o_retry_cnt;
  logic          o_busy;
`ifdef ARQ_CTRL_STATS_EN
  logic [15:0]   o_stat_retx;
  logic [15:0]   o_stat_drop;

  modport master (
    output i_arq_en, i_frame_data_valid, i_frame_data_fas,
    output i_ack_valid, i_ack,
    input  o_send_hold, o_line_retrans_req, o_frame_drop,
    input  o_retry_cnt, o_busy, o_stat_retx, o_stat_drop
  );

  modport slave (
    input  i_arq_en, i_frame_data_valid, i_frame_data_fas,
    input  i_ack_valid, i_ack,
    output o_send_hold, o_line_retrans_req, o_frame_drop,
    output o_retry_cnt, o_busy, o_stat_retx, o_stat_drop
  );
`else
  modport master (
    output i_arq_en, i_frame_data_valid, i_frame_data_fas,
    output i_ack_valid, i_ack,
    input  o_send_hold, o_line_retrans_req, o_frame_drop,
    input  o_retry_cnt, o_busy
  );

  modport slave (
    input  i_arq_en, i_frame_data_valid, i_frame_data_fas,
    input  i_ack_valid, i_ack,
    output o_send_hold, o_line_retrans_req, o_frame_drop,
    output o_retry_cnt, o_busy
  );
`endif

endinterface

// File: rtl/arq_timer.sv
// arq_timer: loadable up-counter, stops at LAST and flags it on o_tc.
// Ports: i_clk, i_rst, i_clr (to 0), i_load (to 1), i_inc, o_tc (cnt==LAST).
module arq_timer #(
  parameter int W    = 13,
  parameter int LAST = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_inc,
  output logic o_tc
);

  logic [W-1:0] cnt;

  assign o_tc = (cnt == W'(LAST));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= W'(1);
    end else if (i_inc && !o_tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/arq_ctrl.sv
// arq_ctrl: stop-and-wait ARQ sequencer beside the mapper (sender path).
// Ports: i_clk, i_rst (sync, high), bus (arq_ctrl_if.slave: mapper valid/FAS,
// ACK/NAK in; send hold, retrans pulse, drop pulse, retry count, busy out).
// Optional ARQ_CTRL_STATS_EN adds saturating RETX/DROP entry counters.
module arq_ctrl
  import arq_ctrl_pkg::*;
#(
  parameter int FRAME_LEN   = ARQ_FRAME_LEN,
  parameter int ACK_TIMEOUT = ARQ_ACK_TIMEOUT,
  parameter int MAX_RETRY   = ARQ_MAX_RETRY
) (
  input  logic      i_clk,
  input  logic      i_rst,
  arq_ctrl_if.slave bus
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  arq_state_e    state;
  arq_state_e    nxt;
  logic [RW-1:0] retry;
  logic          byte_armed;
  logic          byte_tc;
  logic          to_tc;
  logic          fas_v;
  logic          data_v;
  logic          byte_clr;
  logic          byte_load;
  logic          byte_inc;
  logic          to_clr;
  logic          to_inc;
  logic          fail;
  logic          to_retx;
  logic          to_drop;

  assign fas_v  = bus.i_frame_data_valid && bus.i_frame_data_fas;
  assign data_v = bus.i_frame_data_valid && !bus.i_frame_data_fas;
  assign fail   = bus.i_ack_valid ? !bus.i_ack : to_tc;

  always_comb begin
    nxt = state;
    if (!bus.i_arq_en) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (fas_v) nxt = ST_SEND;
        ST_SEND: if (data_v && byte_armed && byte_tc) nxt = ST_WAIT;
        ST_WAIT: begin
          if (bus.i_ack_valid && bus.i_ack) begin
            nxt = ST_IDLE;
          end else if (fail) begin
            nxt = (retry == RW'(MAX_RETRY)) ? ST_DROP : ST_RETX;
          end
        end
        ST_RETX: nxt = ST_SEND;
        ST_DROP: nxt = ST_IDLE;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  assign to_retx = (state == ST_WAIT) && (nxt == ST_RETX);
  assign to_drop = (state == ST_WAIT) && (nxt == ST_DROP);

  // Byte count restarts on any FAS; after RETX it stays disarmed
  // until the resent frame's FAS arrives.
  assign byte_clr  = (nxt != ST_SEND);
  assign byte_load = fas_v && bus.i_arq_en &&
                     (state == ST_IDLE || state == ST_SEND);
  assign byte_inc  = (state == ST_SEND) && data_v && byte_armed;

  assign to_clr = (nxt != ST_WAIT);
  assign to_inc = (state == ST_WAIT);

  arq_timer #(
    .W    (BW),
    .LAST (FRAME_LEN - 1)
  ) u_byte_tmr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (byte_clr),
    .i_load (byte_load),
    .i_inc  (byte_inc),
    .o_tc   (byte_tc)
  );

  arq_timer #(
    .W    (TW),
    .LAST (ACK_TIMEOUT - 1)
  ) u_to_tmr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (to_clr),
    .i_load (1'b0),
    .i_inc  (to_inc),
    .o_tc   (to_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_armed <= 1'b0;
    end else if (byte_clr) begin
      byte_armed <= 1'b0;
    end else if (byte_load) begin
      byte_armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      retry <= '0;
    end else begin
      state <= nxt;
      if (to_retx) begin
        retry <= retry + 1'b1;
      end else if (nxt == ST_IDLE || nxt == ST_DROP) begin
        retry <= '0;
      end
    end
  end

  assign bus.o_send_hold        = (state == ST_WAIT) ||
                                  (state == ST_RETX);
  assign bus.o_line_retrans_req = (state == ST_RETX);
  assign bus.o_frame_drop       = (state == ST_DROP);
  assign bus.o_retry_cnt        = retry;
  assign bus.o_busy             = (state != ST_IDLE);

`ifdef ARQ_CTRL_STATS_EN
  logic [15:0] stat_retx;
  logic [15:0] stat_drop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_retx <= '0;
      stat_drop <= '0;
    end else begin
      if (to_retx && stat_retx != 16'hFFFF) begin
        stat_retx <= stat_retx + 16'd1;
      end
      if (to_drop && stat_drop != 16'hFFFF) begin
        stat_drop <= stat_drop + 16'd1;
      end
    end
  end

  assign bus.o_stat_retx = stat_retx;
  assign bus.o_stat_drop = stat_drop;
`endif

endmodule
